tsi_sync_debounce: RTL
======================

# tsi_sync_debounce

Parametrised board-I/O conditioning block between the raw FPGA pads and the UART core. It synchronises N_SW configuration switches into the clock domain, debounces them, and reports each debounced change. It also synchronises the serial RX line, with an optional glitch filter, and registers the TX and LED outputs. It asserts a configuration-valid flag once the switch values have settled after reset.

## Interface
- N_SW, 7, number of switch channels (baud[3:0], eight, pen, ohel); minimum 1
- N_LED, 16, LED output width
- SYNC_STAGES, 2, synchroniser flops per input; minimum 2
- DB_CYCLES, 1000000, consecutive stable cycles required to accept a switch change (10 ms at 100 MHz); minimum 2
- i_clk  in  1  single system clock
- i_rst  in  1  reset; synchronous, active-low (asserted while 0)
- i_sw  in  N_SW  raw switch pads
- i_rx  in  1  raw serial RX pad
- i_tx  in  1  TX bit from UART core
- i_led  in  N_LED  LED data from core
- o_sw  out  N_SW  debounced switch values
- o_sw_chg  out  N_SW  one-cycle pulse per channel on debounced change
- o_rx  out  1  synchronised (optionally filtered) RX
- o_tx  out  1  registered TX
- o_led  out  N_LED  registered LEDs
- o_cfg_vld  out  1  high once the startup settle window has completed

## Operation
- Reset values: o_sw=0, o_sw_chg=0, o_rx=1, o_tx=1, o_led=0, o_cfg_vld=0.
- Reset values of the synchroniser flops: switch flops 0; RX flops 1 (line idle high).
- Each channel:
  - raw pad → SYNC_STAGES flops → sync bit.
  - Counter width is $clog2(DB_CYCLES).
  - sync == o_sw: counter cleared.
  - sync != o_sw: counter increments.
  - Counter at DB_CYCLES-1 with sync still != o_sw: o_sw <= sync, counter cleared, o_sw_chg pulses if o_cfg_vld.
- A bounce (sync returning to o_sw) clears the counter, so only DB_CYCLES consecutive mismatching cycles are accepted.
- Channels are fully independent. Simultaneous changes on several channels produce simultaneous pulses.
- Startup counter:
  - Counts from reset release.
  - o_cfg_vld rises at edge SYNC_STAGES+DB_CYCLES after release and stays high until the next reset.
  - o_sw updates at or before that edge do not pulse o_sw_chg.
- o_tx and o_led are plain registers of i_tx and i_led.
- Reset mid-count clears all counters, synchronisers and outputs at that edge. o_cfg_vld drops at the same edge.

## Timing
- Switch latency: a clean raw change appears on o_sw exactly SYNC_STAGES+DB_CYCLES edges after first being sampled.
- o_sw_chg is high for exactly one cycle, coincident with the first cycle of the new o_sw value.
- o_rx latency: SYNC_STAGES edges without the filter; SYNC_STAGES+3 with it.
- o_tx and o_led latency: 1 edge.
- No combinational paths from inputs to outputs.

## Configuration
- TSI_RX_FILTER_EN defined:
  - The RX sync bit feeds a 3-bit history shift register.
  - o_rx is registered as the majority of the 3 history bits.
  - Single-cycle glitches are suppressed.
  - History bits reset to 1.
- TSI_RX_FILTER_EN undefined: o_rx is the last synchroniser stage; glitches pass through unchanged.

## Structure
- Package tsi_pkg holds:
  - default constants: TSI_N_SW, TSI_N_LED, TSI_SYNC_STAGES, TSI_DB_CYCLES;
  - channel-index localparams for the switch bits: BAUD_LSB, BAUD_MSB, EIGHT_IDX, PEN_IDX, OHEL_IDX.
- Sub-module tsi_debounce_ch:
  - one channel's synchroniser, counter, o_sw bit and change pulse;
  - instantiated N_SW times by a generate loop;
  - receives o_cfg_vld as the pulse mask.
- The top holds the startup counter, the RX path, and the TX/LED registers.

## Test plan
Bench parameters: DB_CYCLES=8, SYNC_STAGES=2.
- Hold i_rst=0 for 3 cycles with random inputs → every output at its reset value; o_cfg_vld=0.
- Release reset with i_sw=7'h25 held → o_sw=7'h25 and o_cfg_vld=1 at edge 10 after release; o_sw_chg never pulses.
- After o_cfg_vld, set i_sw[0] 0→1 → o_sw[0]=1 exactly 10 edges later; o_sw_chg=7'h01 for one cycle.
- Flip i_sw[3] for 5 cycles then restore; then inject 1-cycle glitches every 4 cycles → o_sw[3] unchanged, no pulse.
- RX glitch and valid low:
  - 1-cycle low glitch on i_rx: with filter, o_rx stays 1; without, o_rx is low for 1 cycle, 2 edges later.
  - 16-cycle low on i_rx: o_rx falls at edge 5 (filter) or edge 2 (no filter).
- Mismatch i_sw[1] for 5 cycles, then assert reset:
  - all outputs return to reset values and o_cfg_vld=0;
  - after release, i_led=16'hA5C3 and i_tx=0 give o_led=16'hA5C3 and o_tx=0 one edge later.

Source files
------------

// File: rtl/tsi_pkg.sv
// tsi_pkg: default sizing, switch channel map and helpers shared by tsi_sync_debounce
package tsi_pkg;
  localparam int TSI_N_SW        = 7;
  localparam int TSI_N_LED       = 16;
  localparam int TSI_SYNC_STAGES = 2;
  localparam int TSI_DB_CYCLES   = 1000000;
  localparam int BAUD_LSB  = 0;
  localparam int BAUD_MSB  = 3;
  localparam int EIGHT_IDX = 4;
  localparam int PEN_IDX   = 5;
  localparam int OHEL_IDX  = 6;
  function automatic logic maj3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction
endpackage

// File: rtl/tsi_debounce_ch.sv
// tsi_debounce_ch: one switch channel - synchroniser, stability counter, debounced bit and change pulse
module tsi_debounce_ch
  import tsi_pkg::*;
#(
  parameter int SYNC_STAGES = TSI_SYNC_STAGES,
  parameter int DB_CYCLES   = TSI_DB_CYCLES
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_sw,
  input  logic i_vld,
  output logic o_sw,
  output logic o_sw_chg
);
  localparam int CW = $clog2(DB_CYCLES);
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic sw_q, sw_d, chg_q, chg_d, diff, take;
  // count consecutive mismatches against the debounced bit; accept on the DB_CYCLES-th
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], i_sw};
    diff   = sync_q[SYNC_STAGES-1] ^ sw_q;
    take   = diff && (cnt_q == CW'(DB_CYCLES - 1));
    cnt_d  = (diff && !take) ? cnt_q + 1'b1 : '0;
    sw_d   = take ? sync_q[SYNC_STAGES-1] : sw_q;
    chg_d  = take & i_vld;
  end
  // channel state; synchroniser and debounced bit reset low
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      sync_q <= '0;
      cnt_q  <= '0;
      sw_q   <= 1'b0;
      chg_q  <= 1'b0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      sw_q   <= sw_d;
      chg_q  <= chg_d;
    end
  end
  assign o_sw     = sw_q;
  assign o_sw_chg = chg_q;
endmodule

// File: rtl/tsi_sync_debounce.sv
// tsi_sync_debounce: pad conditioning - switch debounce, RX sync (TSI_RX_FILTER_EN adds a 3-tap majority filter), TX/LED registers
module tsi_sync_debounce
  import tsi_pkg::*;
#(
  parameter int N_SW        = TSI_N_SW,
  parameter int N_LED       = TSI_N_LED,
  parameter int SYNC_STAGES = TSI_SYNC_STAGES,
  parameter int DB_CYCLES   = TSI_DB_CYCLES
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [N_SW-1:0]  i_sw,
  input  logic             i_rx,
  input  logic             i_tx,
  input  logic [N_LED-1:0] i_led,
  output logic [N_SW-1:0]  o_sw,
  output logic [N_SW-1:0]  o_sw_chg,
  output logic             o_rx,
  output logic             o_tx,
  output logic [N_LED-1:0] o_led,
  output logic             o_cfg_vld
);
  localparam int SCW = $clog2(SYNC_STAGES + DB_CYCLES);
  logic [SCW-1:0] st_q, st_d;
  logic vld_q, vld_d, tx_q, tx_d;
  logic [SYNC_STAGES-1:0] rx_sync_q, rx_sync_d;
  logic [N_LED-1:0] led_q, led_d;
  for (genvar i = 0; i < N_SW; i++) begin : g_ch
    tsi_debounce_ch #(
      .SYNC_STAGES(SYNC_STAGES),
      .DB_CYCLES  (DB_CYCLES)
    ) u_ch (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_sw    (i_sw[i]),
      .i_vld   (vld_q),
      .o_sw    (o_sw[i]),
      .o_sw_chg(o_sw_chg[i])
    );
  end
  // startup window: valid flag rises on the edge the first switch values can land, then holds
  always_comb begin
    st_d      = vld_q ? st_q : st_q + 1'b1;
    vld_d     = vld_q | (st_q == SCW'(SYNC_STAGES + DB_CYCLES - 1));
    rx_sync_d = {rx_sync_q[SYNC_STAGES-2:0], i_rx};
    tx_d      = i_tx;
    led_d     = i_led;
  end
  // top-level state; RX line idles high
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      st_q      <= '0;
      vld_q     <= 1'b0;
      rx_sync_q <= '1;
      tx_q      <= 1'b1;
      led_q     <= '0;
    end else begin
      st_q      <= st_d;
      vld_q     <= vld_d;
      rx_sync_q <= rx_sync_d;
      tx_q      <= tx_d;
      led_q     <= led_d;
    end
  end
`ifdef TSI_RX_FILTER_EN
  logic [2:0] hist_q, hist_d;
  logic rx_q, rx_d;
  // three-sample history voted by majority so a single-cycle glitch never reaches o_rx
  always_comb begin
    hist_d = {hist_q[1:0], rx_sync_q[SYNC_STAGES-1]};
    rx_d   = maj3(hist_q);
  end
  // filter state resets to idle
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      hist_q <= '1;
      rx_q   <= 1'b1;
    end else begin
      hist_q <= hist_d;
      rx_q   <= rx_d;
    end
  end
  assign o_rx = rx_q;
`else
  assign o_rx = rx_sync_q[SYNC_STAGES-1];
`endif
  assign o_tx      = tx_q;
  assign o_led     = led_q;
  assign o_cfg_vld = vld_q;
endmodule
